ama_riscv_perf_cnt: RTL
=======================

AMA_RISCV_PERF_CNT -- requirements
Module: ama_riscv_perf_cnt

Interface
REQ-001 SHALL have parameter CNT_W, default 64, sets the counter width in bits; legal values are 33..64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port inst_wb_nop_or_clear, input, 1 bit: 0 = valid instruction retiring in WB this cycle.
REQ-005 SHALL have port stall_id, input, 1 bit: 1 = ID stage stalled this cycle.
REQ-006 SHALL have port mmio_reset_cnt, input, 1 bit: 1 = clear all counters this cycle.
REQ-007 SHALL have port csr_we, input, 1 bit: register write strobe.
REQ-008 SHALL have port csr_re, input, 1 bit: register read strobe.
REQ-009 SHALL have port csr_addr, input, 4 bits: word index of the register.
REQ-010 SHALL have port csr_wdata, input, 32 bits: write data.
REQ-011 SHALL have port csr_rdata, output, 32 bits: read data, registered.
REQ-012 SHALL have port csr_rvalid, output, 1 bit: csr_rdata is valid this cycle.

Function
REQ-013 SHALL implement the register map: 0 CTRL; 1 CYCLE_LO; 2 CYCLE_HI; 3 INSTR_LO; 4 INSTR_HI; 5 STALL_LO; 6 STALL_HI; 7..15 read 0, writes ignored.
REQ-014 SHALL define CTRL as: bit0 run (RW); bit1 clear (write 1 to clear, self-clearing, reads 0); bits 4:2 overflow sticky flags for cycle/instr/stall (RO); other bits read 0.
REQ-015 SHALL implement a 2-state FSM: STOPPED and RUNNING; run=1 selects RUNNING, run=0 selects STOPPED.
REQ-016 SHALL have a CTRL write take effect on the cycle after the write, so an event in the write cycle is still counted (or not counted) under the old state.
REQ-017 SHALL, in RUNNING, increment the cycle counter by 1 on every cycle.
REQ-018 SHALL, in RUNNING, increment the instr counter when inst_wb_nop_or_clear==0.
REQ-019 SHALL, in RUNNING, increment the stall counter when stall_id==1.
REQ-020 SHALL hold all counters in STOPPED.
REQ-021 SHALL wrap counters modulo 2^CNT_W; on the wrap, set the matching CTRL overflow flag, which stays set until the next clear or rst.
REQ-022 SHALL treat mmio_reset_cnt==1 or a CTRL.clear write as a clear: next cycle all counters and overflow flags are 0.
REQ-023 SHALL leave run unchanged on a clear.
REQ-024 SHALL give clear priority over any increment in the same cycle.
REQ-025 SHALL perform a write to counter registers as a direct load of that 32-bit half; the load has priority over the increment in that cycle, and overflow does not apply.
REQ-026 SHALL give a read 1-cycle latency: csr_rdata and csr_rvalid are registered from csr_re/csr_addr.
REQ-027 SHALL pulse csr_rvalid high for exactly 1 cycle per csr_re; back-to-back reads are allowed every cycle.
REQ-028 SHALL make a read of any _LO register latch the matching high bits (zero-extended to 32) into a per-counter shadow in the same cycle.
REQ-029 SHALL return the shadow on _HI reads, not the live value, so a LO-then-HI read is coherent.
REQ-030 SHALL, on a read and a write in the same cycle to the same address, return the pre-write value.
REQ-031 SHALL hold csr_rdata at its last value when csr_rvalid==0.

Reset
REQ-032 SHALL, on rst==1, set all counters, shadows, overflow flags, csr_rdata and csr_rvalid to 0.
REQ-033 SHALL, on rst==1, set run=1 (FSM RUNNING).
REQ-034 SHALL give rst priority over clear, load and increment.
REQ-035 SHALL, with rst asserted mid-read, not assert csr_rvalid in the following cycle.
REQ-036 SHALL, on the first cycle after rst deasserts, count that cycle (CYCLE reads 1 afterward if read at next edge).

Verification
REQ-037 SHALL cover: rst 2 cycles, then 10 cycles with inst_wb_nop_or_clear=0 on 6 of them and stall_id=1 on 3 -> CYCLE_LO=10, INSTR_LO=6, STALL_LO=3.
REQ-038 SHALL cover: write CTRL=0, wait 20 cycles, read CYCLE_LO -> value unchanged from the write cycle +1; write CTRL=1 -> counting resumes.
REQ-039 SHALL cover: load CYCLE_LO=0xFFFFFFFF and CYCLE_HI=0xFFFFFFFF while stopped, then run 1 cycle -> CYCLE=0 and CTRL bit2=1; CTRL reads 0x5.
REQ-040 SHALL cover: CYCLE=0x0000_0001_FFFF_FFFF, read LO, then after 5 running cycles read HI -> HI=0x1 (shadow), not 0x2.
REQ-041 SHALL cover: mmio_reset_cnt=1 in the same cycle as a retire and a stall -> all counters 0 next cycle, run stays 1.
REQ-042 SHALL cover: csr_re to addr 9 -> csr_rdata=0 with csr_rvalid=1 exactly 1 cycle later; then rst asserted during a csr_re -> csr_rvalid=0 on the next cycle.

Source files
------------

// File: rtl/ama_riscv_perf_cnt.sv
// Performance counter block: cycle, retired-instruction and ID-stall counters
// behind a small CSR window, with overflow flags and coherent LO/HI reads.
module ama_riscv_perf_cnt #(
  parameter int unsigned CNT_W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_wb_nop_or_clear,
  input  logic        stall_id,
  input  logic        mmio_reset_cnt,
  input  logic        csr_we,
  input  logic        csr_re,
  input  logic [3:0]  csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_rvalid
);

  localparam int unsigned HI_W  = CNT_W - 32;
  localparam int unsigned N_CNT = 3;

  typedef enum logic {STOPPED, RUNNING} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt     [N_CNT];
  logic [CNT_W-1:0]     cnt_nxt [N_CNT];
  logic [CNT_W:0]       sum     [N_CNT];
  logic [31:0]          shadow  [N_CNT];
  logic [N_CNT-1:0]     ovf;
  logic [N_CNT-1:0]     ovf_nxt;
  logic [N_CNT-1:0]     ev;
  logic                 ctrl_we;
  logic                 clr;
  logic                 running;
  logic [31:0]          rd_mux;

  function automatic logic [31:0] hi_ext(input logic [HI_W-1:0] v);
    return 32'(v);
  endfunction

  assign ctrl_we = csr_we && (csr_addr == 4'd0);
  assign clr     = mmio_reset_cnt || (ctrl_we && csr_wdata[1]);
  assign running = (state == RUNNING);
  // index 0 = cycle, 1 = instr, 2 = stall
  assign ev      = {stall_id, ~inst_wb_nop_or_clear, 1'b1};

  // Per-counter next value: a CSR half-load wins over the increment and never flags overflow
  always_comb begin
    ovf_nxt = ovf;
    for (int unsigned i = 0; i < N_CNT; i++) begin
      sum[i]     = {1'b0, cnt[i]} + (CNT_W+1)'(1);
      cnt_nxt[i] = cnt[i];
      if (csr_we && (csr_addr == 4'(2*i+1))) begin
        cnt_nxt[i][31:0] = csr_wdata;
      end else if (csr_we && (csr_addr == 4'(2*i+2))) begin
        cnt_nxt[i][CNT_W-1:32] = csr_wdata[HI_W-1:0];
      end else if (running && ev[i]) begin
        cnt_nxt[i] = sum[i][CNT_W-1:0];
        ovf_nxt[i] = ovf[i] | sum[i][CNT_W];
      end
    end
  end

  // Read mux over the pre-update register values; HI words come from the shadows
  always_comb begin
    rd_mux = '0;
    case (csr_addr)
      4'd0:    rd_mux = {27'd0, ovf, 1'b0, running};
      4'd1:    rd_mux = cnt[0][31:0];
      4'd2:    rd_mux = shadow[0];
      4'd3:    rd_mux = cnt[1][31:0];
      4'd4:    rd_mux = shadow[1];
      4'd5:    rd_mux = cnt[2][31:0];
      4'd6:    rd_mux = shadow[2];
      default: rd_mux = '0;
    endcase
  end

  // Run/stop FSM and registered CSR read port; a CTRL write only affects the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUNNING;
      csr_rdata  <= '0;
      csr_rvalid <= 1'b0;
    end else begin
      if (ctrl_we) begin
        state <= csr_wdata[0] ? RUNNING : STOPPED;
      end
      csr_rvalid <= csr_re;
      if (csr_re) begin
        csr_rdata <= rd_mux;
      end
    end
  end

  // Counters, overflow flags and HI shadows; clear beats load and increment
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= '0;
      for (int unsigned i = 0; i < N_CNT; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
    end else begin
      ovf <= clr ? '0 : ovf_nxt;
      for (int unsigned i = 0; i < N_CNT; i++) begin
        cnt[i] <= clr ? '0 : cnt_nxt[i];
        if (csr_re && (csr_addr == 4'(2*i+1))) begin
          shadow[i] <= hi_ext(cnt[i][CNT_W-1:32]);
        end
      end
    end
  end

endmodule
